mmio_ctrl: RTL

//  Memory-mapped I/O controller downstream of the single-cycle CPU's data-memory path. Decodes the
//  CPU's data address and services the KEY/SW/HEX/LEDR registers. Synchronises and debounces
//  KEY and SW, holds the HEX and LEDR output registers, and drives the seven-segment decoders.

---
 rtl/mmio_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mmio_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mmio_ctrl                                                       |
// | Purpose  : CPU data-path MMIO block for KEY/SW/HEX/LEDR with debounce.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mmio_ctrl #(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] ADDR_HEX        = 32'hF000_0000,
  parameter logic [DBITS-1:0] ADDR_LEDR       = 32'hF000_0004,
  parameter logic [DBITS-1:0] ADDR_KEY        = 32'hF000_0010,
  parameter logic [DBITS-1:0] ADDR_SW         = 32'hF000_0014,
  parameter int               DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_data,
  output logic [DBITS-1:0] rd_data,
  output logic             is_io,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam int             c_NBITS   = 14;
  localparam int             c_CW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEBOUNCE_CYCLES - 1);

  logic [15:0]        r_hex;
  logic [9:0]         r_ledr;
  logic [c_NBITS-1:0] r_sync1;
  logic [c_NBITS-1:0] r_sync2;
  logic [c_NBITS-1:0] r_db;
  logic [c_CW-1:0]    r_cnt [c_NBITS];
  logic               w_unused_wr_data;

  // Only the low 16 data bits are ever stored.
  assign w_unused_wr_data = ^wr_data[DBITS-1:16];

  // Bits [3:0] are the keys (inverted so pressed = 1), bits [13:4] the switches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {SW, ~KEY};
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_db <= '0;
      for (int i = 0; i < c_NBITS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < c_NBITS; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == c_CNT_MAX) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hex  <= '0;
      r_ledr <= '0;
    end else if (wr_en) begin
      if (addr == ADDR_HEX)  r_hex  <= wr_data[15:0];
      if (addr == ADDR_LEDR) r_ledr <= wr_data[9:0];
    end
  end

  always_comb begin
    rd_data = '0;
    is_io   = 1'b1;
    if (addr == ADDR_HEX)       rd_data = DBITS'(r_hex);
    else if (addr == ADDR_LEDR) rd_data = DBITS'(r_ledr);
    else if (addr == ADDR_KEY)  rd_data = DBITS'(r_db[3:0]);
    else if (addr == ADDR_SW)   rd_data = DBITS'(r_db[13:4]);
    else                        is_io   = 1'b0;
  end

  // Active-low segments ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign HEX0 = seg7(r_hex[3:0]);
  assign HEX1 = seg7(r_hex[7:4]);
  assign HEX2 = seg7(r_hex[11:8]);
  assign HEX3 = seg7(r_hex[15:12]);
  assign LEDR = r_ledr;

endmodule
`default_nettype wire
